// File: rtl/mem_unalign_ctrl_pkg.sv
// Shared definitions for the unaligned-access memory controller: widths,
// FSM state encoding and big-endian byte-lane helpers.
package mem_unalign_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    U_RD2 = 3'd1,
    U_WR1 = 3'd2,
    U_RD3 = 3'd3,
    U_WR2 = 3'd4
  } state_e;

  // Byte lanes of a big-endian word: HI is the byte at the even address.
  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

  function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] w);
    return w[HI_MSB:HI_LSB];
  endfunction

  function automatic logic [7:0] lo_byte(input logic [DATA_W-1:0] w);
    return w[LO_MSB:LO_LSB];
  endfunction

endpackage

// File: rtl/mem_unalign_ctrl_byte_merge.sv
// Combinational byte assembly for split accesses: the read word spanning two
// aligned words, and the two read-modify-write words written back.
module mem_byte_merge
  import mem_unalign_ctrl_pkg::*;
(
  input  logic [7:0]        lo_b,        // low byte of the word at L (first byte of result)
  input  logic [7:0]        mem_rd_hi,   // high byte of the word at H (second byte of result)
  input  logic [7:0]        w0_hi,       // preserved byte of the word at L
  input  logic [7:0]        w1_lo,       // preserved byte of the word at H
  input  logic [DATA_W-1:0] wdata,       // latched write data
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] wr_lo_word,
  output logic [DATA_W-1:0] wr_hi_word
);

  // Straddling read and the two merged write-back words.
  always_comb begin
    rd_word    = {lo_b, mem_rd_hi};
    wr_lo_word = {w0_hi, hi_byte(wdata)};
    wr_hi_word = {lo_byte(wdata), w1_lo};
  end

endmodule

// File: rtl/mem_unalign_ctrl.sv
// Memory-side controller: aligned word accesses pass straight through, odd
// word accesses are split into aligned reads / read-modify-writes while the
// pipeline is stalled. Define MEM_UNALIGN_TRAP_EN to trap odd accesses with
// err instead of splitting them.
module mem_unalign_ctrl
  import mem_unalign_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              done,
  output logic              stall,
  output logic              err,
  input  logic              createdump,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_err,
  output logic              mem_createdump
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        lo_b_q, lo_b_d;
  logic [7:0]        w0_hi_q, w0_hi_d;
  logic [7:0]        w1_lo_q, w1_lo_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] addr_l, addr_h;
  logic [DATA_W-1:0] rd_word, wr_lo_word, wr_hi_word;

  assign mem_createdump = createdump;

  // Neighbouring aligned words of the latched odd address (wrap mod 2^16).
  assign addr_l = addr_q - 16'd1;
  assign addr_h = addr_q + 16'd1;

  mem_byte_merge u_merge (
    .lo_b       (lo_b_q),
    .mem_rd_hi  (hi_byte(mem_data_out)),
    .w0_hi      (w0_hi_q),
    .w1_lo      (w1_lo_q),
    .wdata      (data_q),
    .rd_word    (rd_word),
    .wr_lo_word (wr_lo_word),
    .wr_hi_word (wr_hi_word)
  );

  // State and latched-operand registers; everything is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      lo_b_q  <= '0;
      w0_hi_q <= '0;
      w1_lo_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lo_b_q  <= lo_b_d;
      w0_hi_q <= w0_hi_d;
      w1_lo_q <= w1_lo_d;
      err_q   <= err_d;
    end
  end

  // Next state, downstream strobes and pipeline handshake.
  always_comb begin
    // NOTE: every output and *_d gets a default first so no path infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    lo_b_d       = lo_b_q;
    w0_hi_d      = w0_hi_q;
    w1_lo_d      = w1_lo_q;
    err_d        = err_q;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    cpu_data_out = '0;
    done         = 1'b0;
    stall        = 1'b0;
    err          = 1'b0;

    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (cpu_rd && cpu_wr) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (cpu_rd || cpu_wr) begin
          if (!cpu_addr[0]) begin
            // Aligned: pure pass-through, completes this cycle.
            mem_enable   = 1'b1;
            mem_wr       = cpu_wr;
            mem_addr     = cpu_addr;
            mem_data_in  = cpu_wr ? cpu_data_in : '0;
            cpu_data_out = mem_data_out;
            done         = 1'b1;
            err          = mem_err;
          end else begin
`ifdef MEM_UNALIGN_TRAP_EN
            done = 1'b1;
            err  = 1'b1;
`else
            // First half of any odd access is a read of the word at L.
            mem_enable = 1'b1;
            mem_addr   = cpu_addr - 16'd1;
            stall      = 1'b1;
            addr_d     = cpu_addr;
            err_d      = mem_err;
            if (cpu_rd) begin
              lo_b_d  = lo_byte(mem_data_out);
              state_d = U_RD2;
            end else begin
              w0_hi_d = hi_byte(mem_data_out);
              data_d  = cpu_data_in;
              state_d = U_WR1;
            end
`endif
          end
        end
      end
      U_RD2: begin
        mem_enable   = 1'b1;
        mem_addr     = addr_h;
        cpu_data_out = rd_word;
        done         = 1'b1;
        err          = err_q | mem_err;
        state_d      = IDLE;
      end
      U_WR1: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_l;
        mem_data_in = wr_lo_word;
        stall       = 1'b1;
        err_d       = err_q | mem_err;
        state_d     = U_RD3;
      end
      U_RD3: begin
        mem_enable = 1'b1;
        mem_addr   = addr_h;
        w1_lo_d    = lo_byte(mem_data_out);
        stall      = 1'b1;
        err_d      = err_q | mem_err;
        state_d    = U_WR2;
      end
      U_WR2: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_h;
        mem_data_in = wr_hi_word;
        done        = 1'b1;
        err         = err_q | mem_err;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle aborts the operation: any in-flight access still happens,
    // but no completion is reported to the pipeline.
    if (rst) begin
      done         = 1'b0;
      err          = 1'b0;
      cpu_data_out = '0;
    end
  end

endmodule

// File: tb/tb_mem_unalign_ctrl.sv
// Directed self-checking bench for mem_unalign_ctrl with a byte-array memory
// model and a scoreboard of expected completions. Honours MEM_UNALIGN_TRAP_EN.
module tb_mem_unalign_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr, cpu_data_in, cpu_data_out;
  logic        done, stall, err;
  logic        createdump, mem_createdump;
  logic        mem_enable, mem_wr, mem_err;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, mem_addr_p1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic        tr_en[$];
  logic        tr_wr[$];
  logic        tr_stall[$];
  logic [15:0] tr_addr[$];
  logic [7:0]  mem [0:65535];
  int          ncyc;

  always #5 clk = ~clk;

  // Big-endian combinational memory read.
  assign mem_addr_p1  = mem_addr + 16'd1;
  assign mem_data_out = {mem[mem_addr], mem[mem_addr_p1]};

  mem_unalign_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_rd         (cpu_rd),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_data_in    (cpu_data_in),
    .cpu_data_out   (cpu_data_out),
    .done           (done),
    .stall          (stall),
    .err            (err),
    .createdump     (createdump),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_err        (mem_err),
    .mem_createdump (mem_createdump)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample a pending write, then commit it to the model at the clock edge.
  task automatic tick();
    logic        w_en;
    logic [15:0] w_a, w_a1, w_d;
    w_en = mem_enable && mem_wr;
    w_a  = mem_addr;
    w_a1 = mem_addr + 16'd1;
    w_d  = mem_data_in;
    @(posedge clk);
    if (w_en) begin
      mem[w_a]  = w_d[15:8];
      mem[w_a1] = w_d[7:0];
    end
  endtask

  task automatic go_idle();
    cpu_rd      = 1'b0;
    cpu_wr      = 1'b0;
    cpu_addr    = '0;
    cpu_data_in = '0;
    mem_err     = 1'b0;
  endtask

  // Hold a request until done (bounded), tracing downstream accesses and
  // comparing the completion against the scoreboard head.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input int err_cyc, output int cycles);
    logic got;
    exp_t e;
    got = 1'b0;
    cycles = 0;
    tr_en.delete(); tr_wr.delete(); tr_stall.delete(); tr_addr.delete();
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_data_in = data;
      mem_err = (c == err_cyc);
      #1;
      tr_en.push_back(mem_enable);
      tr_wr.push_back(mem_wr);
      tr_stall.push_back(stall);
      tr_addr.push_back(mem_addr);
      if (mem_enable) check("mem_addr_even", {31'd0, mem_addr[0]}, 32'd0);
      if (done) begin
        got = 1'b1;
        cycles = c + 1;
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.chk_data) check({e.tag, "_data"}, {16'd0, cpu_data_out}, {16'd0, e.data});
          check({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        end
      end
      tick();
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    go_idle();
  endtask

  task automatic push_exp(input string tag, input logic [15:0] data,
                          input logic chk_data, input logic e_err);
    exp_t e;
    e.tag = tag; e.data = data; e.chk_data = chk_data; e.err = e_err;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB;
    mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    go_idle();
    createdump = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data_out", {16'd0, cpu_data_out}, 32'd0);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);

    createdump = 1'b1; #1;
    check("createdump_hi", {31'd0, mem_createdump}, 32'd1);
    createdump = 1'b0; #1;
    check("createdump_lo", {31'd0, mem_createdump}, 32'd0);

    // Aligned read, same-cycle completion.
    push_exp("al_rd10", 16'hAABB, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, -1, ncyc);
    check("al_rd10_cycles", ncyc, 1);
    check("al_rd10_addr", {16'd0, tr_addr[0]}, 32'h10);
    check("al_rd10_stall", {31'd0, tr_stall[0]}, 32'd0);

    // Aligned write then read back.
    push_exp("al_wr20", 16'h0000, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 16'h0020, 16'h5566, -1, ncyc);
    check("al_wr20_cycles", ncyc, 1);
    check("al_wr20_strobe", {31'd0, tr_wr[0]}, 32'd1);
    push_exp("al_rd20", 16'h5566, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, -1, ncyc);

    // Illegal rd&wr.
    push_exp("rdwr", 16'h0000, 1'b1, 1'b1);
    do_req(1'b1, 1'b1, 16'h0010, 16'h0000, -1, ncyc);
    check("rdwr_cycles", ncyc, 1);
    check("rdwr_mem_enable", {31'd0, tr_en[0]}, 32'd0);

`ifdef MEM_UNALIGN_TRAP_EN
    push_exp("trap_rd11", 16'h0000, 1'b0, 1'b1);
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000, -1, ncyc);
    check("trap_rd11_cycles", ncyc, 1);
    check("trap_rd11_mem_enable", {31'd0, tr_en[0]}, 32'd0);
    push_exp("trap_wr11", 16'h0000, 1'b0, 1'b1);
    do_req(1'b0, 1'b1, 16'h0011, 16'h1234, -1, ncyc);
    check("trap_wr11_mem_enable", {31'd0, tr_en[0]}, 32'd0);
    check("trap_wr11_mem_kept", {24'd0, mem[16'h0011]}, 32'hBB);
`else
    // Odd read straddling 0x10/0x12.
    push_exp("odd_rd11", 16'hBBCC, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000, -1, ncyc);
    check("odd_rd11_cycles", ncyc, 2);
    check("odd_rd11_c0_stall", {31'd0, tr_stall[0]}, 32'd1);
    check("odd_rd11_c0_addr", {16'd0, tr_addr[0]}, 32'h10);
    check("odd_rd11_c1_addr", {16'd0, tr_addr[1]}, 32'h12);
    check("odd_rd11_c1_stall", {31'd0, tr_stall[1]}, 32'd0);

    // Odd write: rd/wr/rd/wr at 0x10/0x10/0x12/0x12.
    push_exp("odd_wr11", 16'h0000, 1'b0, 1'b0);
    do_req(1'b0, 1'b1, 16'h0011, 16'h1234, -1, ncyc);
    check("odd_wr11_cycles", ncyc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("odd_wr11_c%0d_wr", i), {31'd0, tr_wr[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("odd_wr11_c%0d_addr", i), {16'd0, tr_addr[i]}, (i < 2) ? 32'h10 : 32'h12);
    end
    check("odd_wr11_m10", {24'd0, mem[16'h0010]}, 32'hAA);
    check("odd_wr11_m11", {24'd0, mem[16'h0011]}, 32'h12);
    check("odd_wr11_m12", {24'd0, mem[16'h0012]}, 32'h34);
    check("odd_wr11_m13", {24'd0, mem[16'h0013]}, 32'hDD);

    // Wrap-around odd read at 0xFFFF.
    push_exp("odd_rdffff", 16'h5AC3, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 16'hFFFF, 16'h0000, -1, ncyc);
    check("odd_rdffff_c0_addr", {16'd0, tr_addr[0]}, 32'hFFFE);
    check("odd_rdffff_c1_addr", {16'd0, tr_addr[1]}, 32'h0000);

    // Downstream error in the first half still completes, with err.
    push_exp("odd_rd13_memerr", 16'hDD00, 1'b1, 1'b1);
    do_req(1'b1, 1'b0, 16'h0013, 16'h0000, 0, ncyc);
    check("odd_rd13_memerr_cycles", ncyc, 2);

    // Reset while in U_WR1: the L write lands, nothing after it.
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB;
    mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
    @(negedge clk);
    cpu_wr = 1'b1; cpu_addr = 16'h0011; cpu_data_in = 16'h1234;
    #1;
    check("rstmid_c0_stall", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    go_idle();
    rst = 1'b1;
    #1;
    check("rstmid_wr1_mem_wr", {31'd0, mem_wr}, 32'd1);
    check("rstmid_wr1_data", {16'd0, mem_data_in}, 32'hAA12);
    check("rstmid_wr1_done", {31'd0, done}, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_after_stall", {31'd0, stall}, 32'd0);
    check("rstmid_after_done", {31'd0, done}, 32'd0);
    check("rstmid_after_enable", {31'd0, mem_enable}, 32'd0);
    check("rstmid_m11", {24'd0, mem[16'h0011]}, 32'h12);
    check("rstmid_m12", {24'd0, mem[16'h0012]}, 32'hCC);
    push_exp("rstmid_readback", 16'hAA12, 1'b1, 1'b0);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, -1, ncyc);
`endif

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
